// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                fetch FSM state encoding, default address width and
//                instruction width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int INSTR_W        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pc_counter
//  Description : Program counter register. Reset loads RST_PC, a load
//                (jump) takes priority over increment, and increment wraps
//                modulo 2^ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_counter
    import cpu_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // PC register: jump load wins over sequential increment; natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RST_PC;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_pc = r_pc;

endmodule : pc_counter
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch unit. Three-state FSM (IDLE/FETCH/VALID)
//                issues a read at the PC, captures the returned byte into
//                the instruction register and hands it downstream with a
//                valid/ready handshake. Jumps have priority in every state
//                and discard any coincident memory data.
//                Optional build macro IFETCH_TIMEOUT_EN adds a FETCH
//                watchdog that raises a sticky fault after TIMEOUT cycles
//                without mem_ack; otherwise fault is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RST_PC  = '0,
    parameter int                TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               jmp_en,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               fault
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_pc_load;
    logic               w_pc_inc;
    logic               w_instr_load;
    logic               w_timeout_hit;
    logic               w_fault;

    pc_counter #(
        .ADDR_W (ADDR_W),
        .RST_PC (RST_PC)
    ) u_pc_counter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_pc_load),
        .i_load_addr (jmp_addr),
        .i_inc       (w_pc_inc),
        .o_pc        (w_pc)
    );

    // FSM state register; reset aborts any fetch in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; a jump pre-empts everything else.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_instr_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (jmp_en) begin
                    w_pc_load = 1'b1;
                end
                if (en) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Request is held regardless of en until the ack arrives.
                if (jmp_en) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = en ? FETCH : IDLE;
                end else if (mem_ack) begin
                    w_instr_load = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_state_nxt  = VALID;
                end else if (w_timeout_hit) begin
                    w_state_nxt = IDLE;
                end
            end
            VALID: begin
                // A handoff coincident with a jump is still consumed.
                if (jmp_en) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = en ? FETCH : IDLE;
                end else if (instr_ready) begin
                    w_state_nxt = en ? FETCH : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A latched fault parks the unit in IDLE until reset.
        if (w_fault) begin
            w_state_nxt = IDLE;
        end
    end

    // Instruction register: only updated by a non-jump acked fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= '0;
        end else if (w_instr_load) begin
            r_instr <= mem_rdata;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    localparam int C_TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [C_TCNT_W-1:0] r_tcnt;
    logic                r_fault;
    logic                w_fetch_stall;

    // A stalled FETCH cycle is one with neither an ack nor a jump.
    assign w_fetch_stall = (r_state == FETCH) && !mem_ack && !jmp_en;
    // The TIMEOUT-th consecutive stalled cycle trips the watchdog.
    assign w_timeout_hit = w_fetch_stall && (r_tcnt == C_TCNT_W'(TIMEOUT - 1));

    // Stall counter: clears on ack, jump, or any cycle outside FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_fetch_stall && !w_timeout_hit) begin
            r_tcnt <= r_tcnt + {{(C_TCNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_tcnt <= '0;
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_timeout_hit) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault = r_fault;
`else
    // Without the watchdog FETCH waits indefinitely for mem_ack.
    assign w_timeout_hit = 1'b0;
    assign w_fault       = 1'b0;
`endif

    assign mem_req     = (r_state == FETCH);
    assign mem_addr    = w_pc;
    assign pc          = w_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == VALID);
    assign fault       = w_fault;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch: table of per-cycle
//                vectors with hand-computed post-edge outputs, plus
//                sequences for asynchronous reset and fetch timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    typedef struct {
        logic       en;
        logic       jmp;
        logic [7:0] ja;
        logic       ack;
        logic [7:0] rd;
        logic       rdy;
        logic       e_req;
        logic [7:0] e_addr;
        logic [7:0] e_instr;
        logic       e_vld;
        logic [7:0] e_pc;
    } vec_t;

    localparam int NV = 22;

    logic       clk;
    logic       rst;
    logic       en;
    logic       jmp_en;
    logic [7:0] jmp_addr;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc;
    logic       fault;

    int   n_checks;
    int   n_errors;
    vec_t vecs [NV];

    instr_fetch #(
        .ADDR_W  (8),
        .RST_PC  (8'h00),
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic j, input logic [7:0] ja,
                                input logic a, input logic [7:0] rd, input logic r,
                                input logic xreq, input logic [7:0] xaddr,
                                input logic [7:0] xinstr, input logic xvld,
                                input logic [7:0] xpc);
        vec_t v;
        v.en = e; v.jmp = j; v.ja = ja; v.ack = a; v.rd = rd; v.rdy = r;
        v.e_req = xreq; v.e_addr = xaddr; v.e_instr = xinstr;
        v.e_vld = xvld; v.e_pc = xpc;
        return v;
    endfunction

    task automatic drive(input logic e, input logic j, input logic [7:0] ja,
                         input logic a, input logic [7:0] rd, input logic r);
        en = e; jmp_en = j; jmp_addr = ja; mem_ack = a; mem_rdata = rd; instr_ready = r;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        //              en    jmp   ja     ack   rd     rdy   req   addr   instr  vld   pc
        vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
        vecs[1]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b1, 8'h01);
        vecs[2]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b1, 8'h01);
        vecs[3]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b1, 8'h01);
        vecs[4]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b1, 8'h01);
        vecs[5]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b1, 8'h01);
        vecs[6]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b1, 8'h01);
        vecs[7]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 8'hA5, 1'b0, 8'h01);
        vecs[8]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h02, 8'h3C, 1'b1, 8'h02);
        vecs[9]  = mk(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h3C, 1'b0, 8'hFF);
        vecs[10] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 8'h00);
        vecs[11] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h11, 1'b0, 8'h00);
        vecs[12] = mk(1'b1, 1'b1, 8'h40, 1'b1, 8'h77, 1'b0, 1'b1, 8'h40, 8'h11, 1'b0, 8'h40);
        vecs[13] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 8'h41, 8'h22, 1'b1, 8'h41);
        vecs[14] = mk(1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h22, 1'b0, 8'h10);
        vecs[15] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h22, 1'b0, 8'h10);
        vecs[16] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h22, 1'b0, 8'h10);
        vecs[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h11, 8'h5A, 1'b1, 8'h11);
        vecs[18] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 8'h5A, 1'b0, 8'h11);
        vecs[19] = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 8'h11, 8'h5A, 1'b0, 8'h11);
        vecs[20] = mk(1'b0, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 8'h5A, 1'b0, 8'h80);
        vecs[21] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 8'h5A, 1'b0, 8'h80);

        // Reset state, observed while reset is asserted.
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_instr", 32'(instr), 32'h00);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven per-cycle vectors: drive, clock, check post-edge outputs.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].en, vecs[i].jmp, vecs[i].ja, vecs[i].ack, vecs[i].rd, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].e_instr));
            chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
            chk($sformatf("v%0d_fault", i), 32'(fault), 32'h0);
        end

        // Asynchronous reset mid-fetch: takes effect without a clock edge.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'h0);
        chk("arst_pc", 32'(pc), 32'h00);
        chk("arst_instr", 32'(instr), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // Fetch with memory never acknowledging.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk("to_enter_fetch", 32'(mem_req), 32'h1);
        repeat (14) @(posedge clk);
        #1;
        chk("to_14_req", 32'(mem_req), 32'h1);
        chk("to_14_fault", 32'(fault), 32'h0);
        @(posedge clk);
        #1;
`ifdef IFETCH_TIMEOUT_EN
        chk("to_15_fault", 32'(fault), 32'h1);
        chk("to_15_req", 32'(mem_req), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_sticky_fault", 32'(fault), 32'h1);
        chk("to_stuck_idle", 32'(mem_req), 32'h0);
        rst = 1'b1;
        #1;
        chk("to_rst_fault", 32'(fault), 32'h0);
        @(negedge clk);
        rst = 1'b0;
`else
        chk("nto_15_fault", 32'(fault), 32'h0);
        chk("nto_15_req", 32'(mem_req), 32'h1);
        repeat (20) @(posedge clk);
        #1;
        chk("nto_35_fault", 32'(fault), 32'h0);
        chk("nto_35_req", 32'(mem_req), 32'h1);
        chk("nto_35_addr", 32'(mem_addr), 32'h00);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8: program-counter and memory address width.
REQ-002 Parameter RST_PC, default 0: PC value loaded on reset.
REQ-003 Parameter TIMEOUT, default 15: cycles in FETCH without mem_ack before fault (only with IFETCH_TIMEOUT_EN).
REQ-004 clk  in  1  clock; all state changes on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  fetch enable; low requests halt.
REQ-007 jmp_en  in  1  load PC from jmp_addr and flush.
REQ-008 jmp_addr  in  ADDR_W  jump target.
REQ-009 mem_req  out  1  memory read request.
REQ-010 mem_addr  out  ADDR_W  read address; equals pc.
REQ-011 mem_ack  in  1  read data valid this cycle.
REQ-012 mem_rdata  in  8  instruction byte.
REQ-013 instr  out  8  registered instruction for the instruction register.
REQ-014 instr_valid  out  1  instr holds an unconsumed instruction.
REQ-015 instr_ready  in  1  downstream accepts instr.
REQ-016 pc  out  ADDR_W  current program counter.
REQ-017 fault  out  1  sticky fetch-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, VALID; state is registered.
REQ-019 IDLE: mem_req=0, instr_valid=0; go FETCH when en=1.
REQ-020 FETCH: mem_req=1, mem_addr=pc; on mem_ack=1, instr<=mem_rdata, pc<=pc+1, go VALID; otherwise stay.
REQ-021 mem_req SHALL stay high until mem_ack even if en falls (no abandoned transaction).
REQ-022 VALID: instr_valid=1, instr stable; on instr_ready=1 go FETCH if en=1 else IDLE; minimum one cycle between consecutive instr_valid handoffs is not required beyond this FSM (throughput 1 instr per 2 cycles with zero-wait memory).
REQ-023 pc increment SHALL wrap modulo 2^ADDR_W (8'hFF -> 8'h00).
REQ-024 jmp_en=1 in any state has priority: pc<=jmp_addr, instr_valid cleared next cycle, a coincident mem_ack is discarded (instr and pc not updated from it), next state FETCH if en=1 else IDLE.
REQ-025 instr_valid and instr_ready both high with jmp_en=1: handoff counts as consumed; jump still applied.
REQ-026 fault=1 forces IDLE and blocks leaving IDLE until reset.

Reset
REQ-027 On rst: state=IDLE, pc=RST_PC, instr=8'h00, instr_valid=0, mem_req=0, fault=0, timeout counter=0; effective immediately, aborting any fetch in progress.

Configuration
REQ-028 Macro IFETCH_TIMEOUT_EN defined: a counter increments each FETCH cycle without mem_ack, clears on ack/jump/leaving FETCH; reaching TIMEOUT sets fault=1, mem_req=0, state IDLE.
REQ-029 Macro undefined: no counter is instantiated, fault is constant 0, FETCH waits indefinitely.

Structure
REQ-030 Package cpu_pkg SHALL hold fetch_state_t enum (IDLE, FETCH, VALID), ADDR_W default and INSTR_W=8.
REQ-031 Sub-module pc_counter SHALL hold the PC register with load (jump), increment and reset-to-RST_PC.

Verification
REQ-032 rst, en=1, memory acks same cycle with 8'hA5 at addr 0 -> mem_addr=0, instr=8'hA5, instr_valid=1, pc=1.
REQ-033 instr_ready=0 for 5 cycles in VALID -> instr stable, mem_req=0; ready=1 -> next fetch at pc=1.
REQ-034 pc=8'hFF fetch acked -> pc=8'h00.
REQ-035 jmp_en=1, jmp_addr=8'h40 coincident with mem_ack -> data discarded, next mem_addr=8'h40, instr_valid=0.
REQ-036 en falls during FETCH with ack after 3 cycles -> mem_req held until ack, instr delivered, then IDLE.
REQ-037 IFETCH_TIMEOUT_EN, TIMEOUT=15, mem_ack never -> fault=1 after 15 FETCH cycles, mem_req=0; rst clears fault.
